mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode into per-cycle datapath controls.
- Produces the 2-bit ALU_Op consumed by the ALU decoder, alongside funct: 00 = add, 01 = subtract, 10 = R-type/funct.
- Sequences fetch, decode, execute, memory and writeback, stalling on a memory ready handshake.

Parameters:
- OPC_W, 6, opcode width.
- ST_W, 4, state register width (12 states used).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register; sampled in DECODE.
- mem_ready  input  1  memory accepted/returned the current access this cycle.
- PC_Write  output  1  unconditional PC load.
- Branch  output  1  conditional PC load when ALU zero = 1.
- Branch_NE  output  1  conditional PC load when ALU zero = 0 (optional feature).
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut.
- Mem_Write  output  1  memory write strobe.
- IR_Write  output  1  instruction register load.
- Reg_Dst  output  1  register write address: 0 = rt, 1 = rd.
- Mem_to_Reg  output  1  register write data: 0 = ALUOut, 1 = memory data.
- Reg_Write  output  1  register file write enable.
- ALU_Src_A  output  1  ALU A operand: 0 = PC, 1 = register A.
- ALU_Src_B  output  2  ALU B operand: 00 = register B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- PC_Src  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALU_Op  output  2  00 = add, 01 = subtract, 10 = R-type.
- instr_done  output  1  last cycle of an instruction.
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.

Behaviour:
- Moore FSM; outputs decode from the state register only, except where mem_ready is listed below.
- Every output not listed for a state is 0.
- Reset: synchronous, active-high. While rst = 1 the state register loads FETCH and illegal_op clears to 0.
  - While rst = 1, PC_Write, IR_Write, Mem_Write and Reg_Write are forced to 0; all other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no partial writeback occurs.
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, BNE = 000101 (optional feature), ADDI = 001000, J = 000010.
- States, outputs and transitions:
  - FETCH: IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=00, PC_Src=00, IR_Write=PC_Write=mem_ready. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - DECODE: ALU_Src_A=0, ALU_Src_B=11, ALU_Op=00 (branch target computed into ALUOut).
    - Next state: LW/SW -> MEMADR; R -> EXECUTE; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP.
    - Any other opcode -> FETCH, with illegal_op = 1 on the next cycle.
  - MEMADR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD: IorD=1. Waits for mem_ready = 1, then -> MEMWB.
  - MEMWB: Reg_Dst=0, Mem_to_Reg=1, Reg_Write=1, instr_done=1. -> FETCH.
  - MEMWR: IorD=1, Mem_Write=1, held until mem_ready = 1. instr_done=mem_ready. -> FETCH on mem_ready.
  - EXECUTE: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=10. -> ALUWB.
  - ALUWB: Reg_Dst=1, Reg_Write=1, instr_done=1. -> FETCH.
  - BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=01, PC_Src=01, Branch=1, instr_done=1. -> FETCH.
  - ADDIEX: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00. -> ADDIWB.
  - ADDIWB: Reg_Dst=0, Mem_to_Reg=0, Reg_Write=1, instr_done=1. -> FETCH.
  - JUMP: PC_Src=10, PC_Write=1, instr_done=1. -> FETCH.
- Latency with mem_ready held at 1: R = 4 cycles, LW = 5, SW = 4, BEQ = 3, ADDI = 4, J = 3. Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Changes on opcode outside DECODE have no effect.
- Unused state encodings go to FETCH on the next clock with all write enables at 0.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 in DECODE -> BRANCH. BRANCH then drives Branch_NE=1 and Branch=0; all other BRANCH outputs are unchanged.
- Undefined: Branch_NE is tied to 0. Opcode 000101 is illegal: DECODE -> FETCH with an illegal_op pulse.

Test Plan:
- rst=1 for 2 cycles, then R-type, mem_ready=1 -> states FETCH, DECODE, EXECUTE, ALUWB. ALU_Op=10 in EXECUTE; Reg_Write=1 and Reg_Dst=1 in ALUWB; instr_done pulses in cycle 4.
- LW with mem_ready low for 3 cycles in MEMRD -> MEMRD held for 4 cycles with IorD=1. MEMWB follows with Mem_to_Reg=1 and Reg_Write=1. Total 8 cycles.
- SW with mem_ready=0 for 2 cycles in MEMWR -> Mem_Write=1 for 3 cycles; instr_done=1 only on the cycle mem_ready=1; then FETCH.
- BEQ then ADDI -> BRANCH: ALU_Op=01, Branch=1, PC_Src=01. ADDIEX: ALU_Op=00, ALU_Src_B=10. ADDIWB: Reg_Write=1, Reg_Dst=0.
- Opcode 111111 -> DECODE then FETCH; illegal_op=1 for exactly 1 cycle; no write enables asserted. With MIPS_CTRL_BNE_EN defined, 000101 -> BRANCH with Branch_NE=1 and Branch=0. Without it, 000101 raises illegal_op.
- rst asserted during MEMWR with mem_ready=0 -> next state FETCH; Mem_Write=0 while rst=1; no instr_done.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller (master) and its datapath (slave).
interface mips_multicycle_control_if #(
    parameter int OPC_W = 6
);
    logic [OPC_W-1:0] opcode;
    logic             mem_ready;
    logic             PC_Write;
    logic             Branch;
    logic             Branch_NE;
    logic             IorD;
    logic             Mem_Write;
    logic             IR_Write;
    logic             Reg_Dst;
    logic             Mem_to_Reg;
    logic             Reg_Write;
    logic             ALU_Src_A;
    logic [1:0]       ALU_Src_B;
    logic [1:0]       PC_Src;
    logic [1:0]       ALU_Op;
    logic             instr_done;
    logic             illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PC_Write, Branch, Branch_NE, IorD, Mem_Write, IR_Write, Reg_Dst,
               Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, PC_Src, ALU_Op,
               instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PC_Write, Branch, Branch_NE, IorD, Mem_Write, IR_Write, Reg_Dst,
               Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, PC_Src, ALU_Op,
               instr_done, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (Moore, mem_ready stalls).
// Define MIPS_CTRL_BNE_EN to decode BNE (opcode 000101) through the BRANCH state.
module mips_multicycle_control #(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_multicycle_control_if.master bus
);
    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
`endif

    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t     state_r;
    state_t     next_s;
    state_t     dec_st_s;
    logic       is_sw_r;
    logic       illegal_op_r;
    logic       illegal_s;
    logic       pc_write_s, branch_s, branch_ne_s, iord_s, mem_write_s, ir_write_s;
    logic       reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s, instr_done_s;
    logic [1:0] alu_src_b_s, pc_src_s, alu_op_s;
`ifdef MIPS_CTRL_BNE_EN
    logic       is_bne_r;
`endif

    // State register plus the opcode attributes that later states need after DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_FETCH;
            illegal_op_r <= 1'b0;
            is_sw_r      <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
            is_bne_r     <= 1'b0;
`endif
        end else begin
            state_r      <= next_s;
            illegal_op_r <= illegal_s;
            if (state_r == S_DECODE) begin
                is_sw_r  <= (bus.opcode == OP_SW);
`ifdef MIPS_CTRL_BNE_EN
                is_bne_r <= (bus.opcode == OP_BNE);
`endif
            end
        end
    end

    // Next-state and per-state control decode; reset decodes as FETCH.
    always_comb begin
        next_s       = S_FETCH;
        illegal_s    = 1'b0;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        branch_ne_s  = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu_op_s     = 2'b00;
        instr_done_s = 1'b0;
        dec_st_s     = rst ? S_FETCH : state_r;

        case (dec_st_s)
            S_FETCH: begin
                alu_src_b_s = 2'b01;
                ir_write_s  = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
                next_s      = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECUTE;
                    OP_BEQ:       next_s = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       next_s = S_BRANCH;
`endif
                    OP_ADDI:      next_s = S_ADDIEX;
                    OP_J:         next_s = S_JUMP;
                    default: begin
                        next_s    = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                next_s      = is_sw_r ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                next_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s       = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = bus.mem_ready;
                next_s       = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
                next_s      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_s    = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = 2'b01;
                pc_src_s     = 2'b01;
                instr_done_s = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
                branch_s     = ~is_bne_r;
                branch_ne_s  = is_bne_r;
`else
                branch_s     = 1'b1;
`endif
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                next_s      = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_src_s     = 2'b10;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
            end
            default: next_s = S_FETCH;
        endcase
    end

    assign bus.PC_Write   = pc_write_s & ~rst;
    assign bus.IR_Write   = ir_write_s & ~rst;
    assign bus.Mem_Write  = mem_write_s & ~rst;
    assign bus.Reg_Write  = reg_write_s & ~rst;
    assign bus.Branch     = branch_s;
`ifdef MIPS_CTRL_BNE_EN
    assign bus.Branch_NE  = branch_ne_s;
`else
    assign bus.Branch_NE  = 1'b0 & branch_ne_s;
`endif
    assign bus.IorD       = iord_s;
    assign bus.Reg_Dst    = reg_dst_s;
    assign bus.Mem_to_Reg = mem_to_reg_s;
    assign bus.ALU_Src_A  = alu_src_a_s;
    assign bus.ALU_Src_B  = alu_src_b_s;
    assign bus.PC_Src     = pc_src_s;
    assign bus.ALU_Op     = alu_op_s;
    assign bus.instr_done = instr_done_s;
    assign bus.illegal_op = illegal_op_r;
endmodule
